// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM state type and default sizing for the matrix-multiply engine
package matmul_pkg;
  typedef enum logic [1:0] {IDLE, COMPUTE, WRITE, DONE} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_VECTOR_SIZE = 8;
  localparam int NN = DEF_VECTOR_SIZE * DEF_VECTOR_SIZE;
endpackage

// File: rtl/matmul_bram.sv
// matmul_bram: simple dual-port RAM, one write port and one registered read port
// Ports: clock/reset (reset clears only the read register), wr_en/wr_addr/din write, rd_addr/dout read.
module matmul_bram
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH = NN
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock) if (wr_en) mem[wr_addr] <= din;
  always_ff @(posedge clock) dout <= reset ? '0 : mem[rd_addr];
endmodule

// File: rtl/matmul_top.sv
// matmul_top: Z = X * Y engine for square matrices held in three row-major RAMs
// Ports: clock/reset, start pulse and sticky done, X and Y write ports, Z registered read port.
module matmul_top
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int VECTOR_SIZE = DEF_VECTOR_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] x_wr_addr,
  input  logic                  x_wr_en,
  input  logic [DATA_WIDTH-1:0] x_din,
  input  logic [ADDR_WIDTH-1:0] y_wr_addr,
  input  logic                  y_wr_en,
  input  logic [DATA_WIDTH-1:0] y_din,
  input  logic [ADDR_WIDTH-1:0] z_addr,
  output logic [DATA_WIDTH-1:0] z_dout
);
  localparam int N = VECTOR_SIZE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t state, state_n;
  logic [CW-1:0] i, j, k;
  logic [DATA_WIDTH-1:0] acc, x_q, y_q, prod;
  logic vld;
  // vld marks that the RAM outputs hold the operands addressed on the previous cycle
  assign prod = x_q * y_q;
  always_comb begin
    state_n = (state == IDLE)    ? (start ? COMPUTE : IDLE) :
              (state == COMPUTE) ? (k == LAST ? WRITE : COMPUTE) :
              (state == WRITE)   ? ((i == LAST && j == LAST) ? DONE : COMPUTE) :
                                   IDLE;
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      {i, j, k} <= '0;
      acc <= '0;
      done <= 1'b0;
      vld <= 1'b0;
    end else begin
      vld <= state == COMPUTE;
      if (state == IDLE && start) begin
        {i, j, k} <= '0;
        acc <= '0;
        done <= 1'b0;
      end else if (state == COMPUTE) begin
        k <= k + 1'b1;
        if (vld) acc <= acc + prod;
      end else if (state == WRITE) begin
        acc <= '0;
        k <= '0;
        j <= (j == LAST) ? '0 : j + 1'b1;
        if (j == LAST) i <= i + 1'b1;
      end else if (state == DONE) begin
        done <= 1'b1;
      end
    end
  end
  matmul_bram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(2 ** ADDR_WIDTH)) u_x (
    .clock(clock), .reset(reset), .wr_en(x_wr_en), .wr_addr(x_wr_addr), .din(x_din),
    .rd_addr(ADDR_WIDTH'(i * N + k)), .dout(x_q)
  );
  matmul_bram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(2 ** ADDR_WIDTH)) u_y (
    .clock(clock), .reset(reset), .wr_en(y_wr_en), .wr_addr(y_wr_addr), .din(y_din),
    .rd_addr(ADDR_WIDTH'(k * N + j)), .dout(y_q)
  );
  // the last product arrives during WRITE, so it is folded straight into the stored sum
  matmul_bram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(2 ** ADDR_WIDTH)) u_z (
    .clock(clock), .reset(reset), .wr_en(state == WRITE), .wr_addr(ADDR_WIDTH'(i * N + j)),
    .din(acc + prod), .rd_addr(z_addr), .dout(z_dout)
  );
endmodule

// File: tb/tb_matmul_top.sv
// tb_matmul_top: table-driven and directed self-checking bench for matmul_top
module tb_matmul_top;
  import matmul_pkg::*;
  logic clock = 0, reset = 1, start = 0, done;
  logic [5:0] x_wr_addr = 0, y_wr_addr = 0, z_addr = 0;
  logic x_wr_en = 0, y_wr_en = 0;
  logic [31:0] x_din = 0, y_din = 0, z_dout;
  logic [31:0] xm [NN], ym [NN], zm [NN];
  int checks = 0, errors = 0, cyc, base_cyc;
  typedef struct {
    string name;
    bit x_ident;
    logic [31:0] x_val;
    logic [31:0] y_val;
    logic [31:0] z_exp;
  } vec_t;
  vec_t vecs [5];

  matmul_top dut (
    .clock(clock), .reset(reset), .start(start), .done(done),
    .x_wr_addr(x_wr_addr), .x_wr_en(x_wr_en), .x_din(x_din),
    .y_wr_addr(y_wr_addr), .y_wr_en(y_wr_en), .y_din(y_din),
    .z_addr(z_addr), .z_dout(z_dout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load();
    for (int a = 0; a < NN; a++) begin
      @(negedge clock);
      x_wr_en = 1; y_wr_en = 1;
      x_wr_addr = 6'(a); y_wr_addr = 6'(a);
      x_din = xm[a]; y_din = ym[a];
    end
    @(negedge clock);
    x_wr_en = 0; y_wr_en = 0;
  endtask

  task automatic model();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        logic [31:0] s;
        s = 0;
        for (int q = 0; q < 8; q++) s = s + xm[r*8+q] * ym[q*8+c];
        zm[r*8+c] = s;
      end
  endtask

  // second_at > 0 issues an extra start pulse that many cycles after the first
  task automatic run(input int second_at, output int cycles);
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    cycles = 1;
    chk("done_cleared_after_start", {31'b0, done}, 32'd0);
    while (!done && cycles < 800) begin
      @(negedge clock);
      cycles++;
      start = (cycles == second_at);
    end
    start = 0;
    checks++;
    if (!done || cycles > 708) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles (done=%b) expected <= 708", cycles, done);
    end
  endtask

  task automatic check_z(input string nm);
    for (int a = 0; a < NN; a++) begin
      @(negedge clock);
      z_addr = 6'(a);
      @(negedge clock);
      chk($sformatf("%s z[%0d]", nm, a), z_dout, zm[a]);
    end
  endtask

  initial begin
    vecs[0] = '{"identity_x_2", 1'b1, 32'd0, 32'd2, 32'h00000002};
    vecs[1] = '{"all_ones_wrap", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000008};
    vecs[2] = '{"msb_wrap", 1'b0, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[3] = '{"three_x_five", 1'b0, 32'd3, 32'd5, 32'd120};
    vecs[4] = '{"identity_x_deadbeef", 1'b1, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF};
    repeat (3) @(negedge clock);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_z_dout", z_dout, 32'd0);
    reset = 0;

    for (int v = 0; v < 5; v++) begin
      for (int a = 0; a < NN; a++) begin
        xm[a] = vecs[v].x_ident ? ((a / 8 == a % 8) ? 32'd1 : 32'd0) : vecs[v].x_val;
        ym[a] = vecs[v].y_val;
        zm[a] = vecs[v].z_exp;
      end
      load();
      run(0, cyc);
      if (v == 0) base_cyc = cyc;
      chk($sformatf("%s done_held", vecs[v].name), {31'b0, done}, 32'd1);
      check_z(vecs[v].name);
    end

    for (int a = 0; a < NN; a++) begin
      xm[a] = $urandom;
      ym[a] = $urandom;
    end
    model();
    load();
    run(0, cyc);
    check_z("random");

    for (int a = 0; a < NN; a++) xm[a] = 32'd0;
    load();
    check_z("no_write_outside_run");

    for (int a = 0; a < NN; a++) begin
      xm[a] = $urandom;
      ym[a] = 32'(a * 7 + 1);
    end
    model();
    load();
    run(10, cyc);
    chk("start_ignored_timing", cyc, base_cyc);
    check_z("start_ignored");

    for (int a = 0; a < NN; a++) xm[a] = $urandom;
    model();
    load();
    @(negedge clock);
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (99) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("midrun_reset_done", {31'b0, done}, 32'd0);
    repeat (720) @(negedge clock);
    chk("midrun_reset_idle", {31'b0, done}, 32'd0);
    run(0, cyc);
    check_z("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
